counter_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single WIDTH-bit counter among NUM_REQ requesters. Each requester issues increment, decrement, load or clear operations through a valid/ready handshake. The arbiter grants at most one operation per cycle, applies it to the counter, and reports completion and wrap events. It sits between client control FSMs and the shared event/sequence counter, replacing direct per-client enable logic.

---
 rtl/counter_share_arbiter.sv | 126 ++++++++++++
 tb/tb_counter_share_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit counter among NUM_REQ requesters.
// Grants at most one inc/dec/load/clear per cycle and reports completion and wrap events.
module counter_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cnt_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         counter,
  output logic                     op_done,
  output logic [IDX_W-1:0]         done_id,
  output logic                     ovf,
  output logic                     unf
);

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] done_id_q, done_id_d;
  logic             op_done_q, op_done_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   cand;
  op_e              grant_op;
  logic [WIDTH-1:0] grant_data;

  // Scan from the highest offset down so the candidate closest to rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req_valid[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
    // No grant while gated or held in reset.
    if (!cnt_en || !rst) grant_valid = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    grant_op   = OP_INC;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_op   = op_e'(req_op[2*i +: 2]);
        grant_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    counter_d = counter_q;
    rr_ptr_d  = rr_ptr_q;
    op_done_d = grant_valid;
    done_id_d = '0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    if (grant_valid) begin
      done_id_d = grant_idx;
      rr_ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      case (grant_op)
        OP_INC: begin
          counter_d = counter_q + WIDTH'(1);
          ovf_d     = &counter_q;
        end
        OP_DEC: begin
          counter_d = counter_q - WIDTH'(1);
          unf_d     = ~|counter_q;
        end
        OP_LOAD: counter_d = grant_data;
        default: counter_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      rr_ptr_q  <= '0;
      op_done_q <= 1'b0;
      done_id_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      rr_ptr_q  <= rr_ptr_d;
      op_done_q <= op_done_d;
      done_id_q <= done_id_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign counter = counter_q;
  assign op_done = op_done_q;
  assign done_id = done_id_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed bench for counter_share_arbiter: reset, round-robin order, wraps, gating, mid-op reset.
// Inputs change just after the falling edge; registered outputs are sampled 1ns after the rising edge.
module tb_counter_share_arbiter;

  logic        clk;
  logic        rst;
  logic        cnt_en;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  counter;
  logic        op_done;
  logic [1:0]  done_id;
  logic        ovf;
  logic        unf;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] INC = 2'b00, DEC = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  counter_share_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_en    (cnt_en),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .counter   (counter),
    .op_done   (op_done),
    .done_id   (done_id),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int idx, input logic v, input logic [1:0] op, input logic [7:0] data);
    req_valid[idx]       = v;
    req_op[2*idx +: 2]   = op;
    req_data[8*idx +: 8] = data;
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  task automatic after_fall();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, INC, 8'h00);
    cnt_en = 1'b1;
    rst    = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (counter !== 8'h00) begin bad++; $display("FAIL reset_counter got=%h exp=00", counter); end
    total++; if (op_done !== 1'b0) begin bad++; $display("FAIL reset_op_done got=%b exp=0", op_done); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL reset_unf got=%b exp=0", unf); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL release_ready got=%b exp=0001", req_ready); end
  endtask

  // All four hold inc; grants rotate 0,1,2,3,0,... and counter climbs by one each cycle.
  task automatic test_round_robin();
    logic [3:0] exp_ready;
    for (int c = 0; c < 8; c++) begin
      exp_ready = 4'b0001 << (c % 4);
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready); end
      after_rise();
      total++; if (op_done !== 1'b1) begin bad++; $display("FAIL rr_op_done[%0d] got=%b exp=1", c, op_done); end
      total++; if (done_id !== 2'(c % 4)) begin bad++; $display("FAIL rr_done_id[%0d] got=%0d exp=%0d", c, done_id, c % 4); end
      total++; if (counter !== 8'(c + 1)) begin bad++; $display("FAIL rr_counter[%0d] got=%0d exp=%0d", c, counter, c + 1); end
      after_fall();
    end
    req_valid = 4'b0000;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_idle_ready got=%b exp=0000", req_ready); end
    after_rise();
    total++; if (op_done !== 1'b0) begin bad++; $display("FAIL rr_idle_op_done got=%b exp=0", op_done); end
    total++; if (counter !== 8'd8) begin bad++; $display("FAIL rr_final_counter got=%0d exp=8", counter); end
    after_fall();
  endtask

  task automatic test_inc_wrap();
    logic [7:0] exp_cnt [3] = '{8'hFE, 8'hFF, 8'h00};
    logic       exp_ovf [3] = '{1'b0, 1'b0, 1'b1};
    drive(2, 1'b1, LOAD, 8'hFE);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL incw_ready got=%b exp=0100", req_ready); end
    for (int s = 0; s < 3; s++) begin
      after_rise();
      total++; if (counter !== exp_cnt[s]) begin bad++; $display("FAIL incw_counter[%0d] got=%h exp=%h", s, counter, exp_cnt[s]); end
      total++; if (ovf !== exp_ovf[s]) begin bad++; $display("FAIL incw_ovf[%0d] got=%b exp=%b", s, ovf, exp_ovf[s]); end
      total++; if (done_id !== 2'd2 || op_done !== 1'b1) begin bad++; $display("FAIL incw_done[%0d] got=%b/%0d exp=1/2", s, op_done, done_id); end
      after_fall();
      drive(2, s < 2, INC, 8'h00);
    end
    after_rise();
    total++; if (ovf !== 1'b0 || op_done !== 1'b0) begin bad++; $display("FAIL incw_quiet got=%b/%b exp=0/0", ovf, op_done); end
    after_fall();
  endtask

  task automatic test_dec_wrap();
    logic [7:0] exp_cnt [3] = '{8'h00, 8'hFF, 8'hFE};
    logic       exp_unf [3] = '{1'b0, 1'b1, 1'b0};
    drive(1, 1'b1, CLR, 8'h00);
    for (int s = 0; s < 3; s++) begin
      after_rise();
      total++; if (counter !== exp_cnt[s]) begin bad++; $display("FAIL decw_counter[%0d] got=%h exp=%h", s, counter, exp_cnt[s]); end
      total++; if (unf !== exp_unf[s]) begin bad++; $display("FAIL decw_unf[%0d] got=%b exp=%b", s, unf, exp_unf[s]); end
      total++; if (done_id !== 2'd1 || ovf !== 1'b0) begin bad++; $display("FAIL decw_id_ovf[%0d] got=%0d/%b exp=1/0", s, done_id, ovf); end
      after_fall();
      drive(1, s < 2, DEC, 8'h00);
    end
  endtask

  // rr_ptr is set to 1 by one accepted op from requester 0, then 0 and 3 wait through gating.
  task automatic test_gating();
    drive(0, 1'b1, LOAD, 8'h10);
    after_rise();
    total++; if (counter !== 8'h10) begin bad++; $display("FAIL gate_setup_counter got=%h exp=10", counter); end
    after_fall();
    cnt_en = 1'b0;
    drive(0, 1'b1, INC, 8'h00);
    drive(3, 1'b1, LOAD, 8'h80);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL gate_ready[%0d] got=%b exp=0000", c, req_ready); end
      after_rise();
      total++; if (counter !== 8'h10 || op_done !== 1'b0) begin bad++; $display("FAIL gate_hold[%0d] got=%h/%b exp=10/0", c, counter, op_done); end
      after_fall();
    end
    cnt_en = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL gate_first_ready got=%b exp=1000", req_ready); end
    after_rise();
    total++; if (counter !== 8'h80 || done_id !== 2'd3) begin bad++; $display("FAIL gate_first got=%h/%0d exp=80/3", counter, done_id); end
    after_fall();
    drive(3, 1'b0, INC, 8'h00);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL gate_second_ready got=%b exp=0001", req_ready); end
    after_rise();
    total++; if (counter !== 8'h81 || done_id !== 2'd0) begin bad++; $display("FAIL gate_second got=%h/%0d exp=81/0", counter, done_id); end
    after_fall();
    drive(0, 1'b0, INC, 8'h00);
  endtask

  task automatic test_reset_mid_op();
    drive(0, 1'b1, LOAD, 8'h55);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ready got=%b exp=0001", req_ready); end
    after_rise();
    total++; if (counter !== 8'h55 || op_done !== 1'b1) begin bad++; $display("FAIL rmid_load got=%h/%b exp=55/1", counter, op_done); end
    drive(0, 1'b0, INC, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    total++; if (counter !== 8'h00) begin bad++; $display("FAIL rmid_counter got=%h exp=00", counter); end
    total++; if (op_done !== 1'b0 || done_id !== 2'd0) begin bad++; $display("FAIL rmid_done got=%b/%0d exp=0/0", op_done, done_id); end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, INC, 8'h00);
    drive(1, 1'b1, INC, 8'h00);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ptr_ready got=%b exp=0001", req_ready); end
    after_rise();
    total++; if (counter !== 8'h01 || done_id !== 2'd0) begin bad++; $display("FAIL rmid_after got=%h/%0d exp=01/0", counter, done_id); end
    after_fall();
    req_valid = 4'b0000;
  endtask

  initial begin
    rst       = 1'b0;
    cnt_en    = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_inc_wrap();
    test_dec_wrap();
    test_gating();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
